// File: rtl/instr_fetch_if.sv
// Instruction-memory strobe/acknowledge bus between the fetch master and memory.
//   o_addr  : memory word address (master -> memory)
//   o_stb   : strobe, held with o_addr until i_ack (master -> memory)
//   o_burst : burst select, always 0 from this master (master -> memory)
//   i_ack   : one-cycle acknowledge (memory -> master)
//   i_instr : read data, valid in the i_ack cycle (memory -> master)
interface instr_fetch_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] o_addr;
  logic              o_stb;
  logic              o_burst;
  logic              i_ack;
  logic [31:0]       i_instr;

  modport master (
    output o_addr,
    output o_stb,
    output o_burst,
    input  i_ack,
    input  i_instr
  );

  modport slave (
    input  o_addr,
    input  o_stb,
    input  o_burst,
    output i_ack,
    output i_instr
  );
endinterface

// File: rtl/instr_fetch_master.sv
// Instruction fetch master: serves IF-stage requests from a one-line buffer of
// BURST_LENGTH words and refills the line from instruction memory on a miss,
// one strobe/ack transaction per word with a one-cycle strobe gap between words.
// Optional feature macro: FETCH_TIMEOUT_EN adds an ack watchdog (TIMEOUT cycles)
// that aborts a stalled fill with a one-cycle o_err pulse.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req, i_pc    : fetch request and byte address (sampled in IDLE only)
//   i_flush        : invalidate the line, abort any fill in progress
//   o_instr,o_valid: fetched instruction with one-cycle valid pulse
//   o_busy         : state is not IDLE
//   o_err          : one-cycle watchdog timeout pulse
//   mem            : instruction memory bus (instr_fetch_if.master)
module instr_fetch_master #(
  parameter int ADDR_W       = 13,
  parameter int BURST_LENGTH = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic [31:0]   i_pc,
  input  logic          i_flush,
  output logic [31:0]   o_instr,
  output logic          o_valid,
  output logic          o_busy,
  output logic          o_err,
  instr_fetch_if.master mem
);
  localparam int OFF_W = $clog2(BURST_LENGTH);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(BURST_LENGTH - 1);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_GAP, S_RESP, S_ERR} state_t;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_n;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_GAP, S_RESP} state_t;
`endif

  state_t            state_q, state_n;
  logic [31:0]       line_q [BURST_LENGTH];
  logic [TAG_W-1:0]  tag_q, tag_n;
  logic [OFF_W-1:0]  off_q, off_n;
  logic [OFF_W-1:0]  idx_q, idx_n;
  logic              line_valid_q, line_valid_n;
  logic              store;
  logic [ADDR_W-1:0] req_waddr;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  req_off;
  logic [OFF_W-1:0]  rd_off;
  logic [31:0]       resp_word;
  logic              unused_bits;

  assign req_waddr = i_pc[ADDR_W+1:2];
  assign req_tag   = req_waddr[ADDR_W-1:OFF_W];
  assign req_off   = req_waddr[OFF_W-1:0];

`ifdef FETCH_TIMEOUT_EN
  assign unused_bits = ^{i_pc[31:ADDR_W+2], i_pc[1:0]};
`else
  assign unused_bits = ^{i_pc[31:ADDR_W+2], i_pc[1:0], (TIMEOUT > 0)};
`endif

  assign o_busy      = (state_q != S_IDLE);
  assign mem.o_burst = 1'b0;

  always_comb begin
    state_n      = state_q;
    tag_n        = tag_q;
    off_n        = off_q;
    idx_n        = idx_q;
    line_valid_n = line_valid_q;
    store        = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wd_n         = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          off_n = req_off;
          // A flush in the same cycle wins, so the request is treated as a miss.
          if (!i_flush && line_valid_q && (req_tag == tag_q)) begin
            state_n = S_RESP;
          end else begin
            state_n      = S_FILL;
            tag_n        = req_tag;
            idx_n        = '0;
            line_valid_n = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wd_n         = '0;
`endif
          end
        end
      end
      S_FILL: begin
        if (i_flush) begin
          state_n = S_IDLE;
        end else if (mem.i_ack) begin
          store = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_n      = S_RESP;
            line_valid_n = 1'b1;
          end else begin
            state_n = S_GAP;
            idx_n   = idx_q + 1'b1;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_n = S_ERR;
        end else begin
          wd_n = wd_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        // One idle strobe cycle lets the responder restart its delay count.
        if (i_flush) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_FILL;
`ifdef FETCH_TIMEOUT_EN
          wd_n    = '0;
`endif
        end
      end
      S_RESP: state_n = S_IDLE;
`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        state_n      = S_IDLE;
        line_valid_n = 1'b0;
      end
`endif
      default: state_n = S_IDLE;
    endcase
    if (i_flush) line_valid_n = 1'b0;
  end

  // Response word: a hit reads the requested offset now; a fill answers with the
  // latched offset, bypassing the array when that word arrives on the final ack.
  always_comb begin
    rd_off    = (state_q == S_IDLE) ? req_off : off_q;
    resp_word = line_q[rd_off];
    if (store && (idx_q == rd_off)) resp_word = mem.i_instr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      tag_q        <= '0;
      off_q        <= '0;
      idx_q        <= '0;
      line_valid_q <= 1'b0;
      o_instr      <= '0;
      o_valid      <= 1'b0;
      mem.o_stb    <= 1'b0;
      mem.o_addr   <= '0;
    end else begin
      state_q      <= state_n;
      tag_q        <= tag_n;
      off_q        <= off_n;
      idx_q        <= idx_n;
      line_valid_q <= line_valid_n;
      o_valid      <= (state_n == S_RESP);
      mem.o_stb    <= (state_n == S_FILL);
      mem.o_addr   <= {tag_n, idx_n};
      if (state_n == S_RESP) o_instr <= resp_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (store) line_q[idx_q] <= mem.i_instr;
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd_q  <= '0;
      o_err <= 1'b0;
    end else begin
      wd_q  <= wd_n;
      o_err <= (state_n == S_ERR);
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
